// File: rtl/cpu_pkg.sv
// Shared opcode values, sequencer state encoding and opcode classification.
// Purely combinational helpers; no latency or flow control of their own.
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        IDLE  = 4'h0,
        T0    = 4'h1,
        T1    = 4'h2,
        T2    = 4'h3,
        T3    = 4'h4,
        T4    = 4'h5,
        T5    = 4'h6,
        T6    = 4'h7,
        HALT  = 4'h8,
        FAULT = 4'h9
    } state_t;

    typedef struct packed {
        logic alu2;
        logic unary;
        logic muldiv;
        logic nop;
        logic halt;
        logic illegal;
    } op_class_t;

    function automatic op_class_t classify_op(input logic [4:0] opc);
        op_class_t c;
        c = '0;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: c.alu2    = 1'b1;
            OP_MUL, OP_DIV:                 c.muldiv  = 1'b1;
            OP_NEG, OP_NOT:                 c.unary   = 1'b1;
            OP_NOP:                         c.nop     = 1'b1;
            OP_HALT:                        c.halt    = 1'b1;
            default:                        c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/op_class_decode.sv
// Maps the IR opcode field onto a one-hot instruction class.
// Combinational, zero latency; no flow control.
module op_class_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    assign op_class = classify_op(opcode);

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit: fetch T0-T2, execute T3-T6, one cycle of strobes per state.
// ALU2/unary 6 cycles, mul/div 7, nop 4; T1 stalls on mem_rdy up to MEM_TIMEOUT cycles.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OP_W        = 5,
    parameter int MEM_TIMEOUT = 15
)(
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic [31:0]     ir,
    input  logic            mem_rdy,
    output logic            PCout,
    output logic            MARin,
    output logic            incPC,
    output logic            Read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            ZLowOut,
    output logic            ZHighOut,
    output logic            HIin,
    output logic            LOin,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic [OP_W-1:0] alu_op,
    output logic            halted,
    output logic            fault,
    output logic [3:0]      state_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    op_class_t        cls;
    logic             unused_ir_bits;

    assign unused_ir_bits = ^ir[26:0];

    op_class_decode u_decode (
        .opcode   (ir[31:27]),
        .op_class (cls)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Strobes depend only on the state register and the already-loaded IR,
    // so an async clear forces every output low within the same cycle.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        PCout    = 1'b0;
        MARin    = 1'b0;
        incPC    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        ZLowOut  = 1'b0;
        ZHighOut = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        alu_op   = '0;

        case (state)
            IDLE: begin
                if (run) state_nxt = T0;
            end
            T0: begin
                PCout        = 1'b1;
                MARin        = 1'b1;
                incPC        = 1'b1;
                wait_cnt_nxt = '0;
                state_nxt    = T1;
            end
            T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                // A ready arriving on the last allowed cycle still wins over the timeout.
                if (mem_rdy) begin
                    state_nxt = T2;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    if (wait_cnt_nxt == CNT_W'(MEM_TIMEOUT)) state_nxt = FAULT;
                end
            end
            T2: begin
                MDRout    = 1'b1;
                IRin      = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                if (cls.alu2 || cls.muldiv) begin
                    Grb       = 1'b1;
                    Rout      = 1'b1;
                    Yin       = 1'b1;
                    state_nxt = T4;
                end else if (cls.unary) begin
                    state_nxt = T4;
                end else if (cls.nop) begin
                    state_nxt = run ? T0 : IDLE;
                end else if (cls.halt) begin
                    state_nxt = HALT;
                end else begin
                    state_nxt = FAULT;
                end
            end
            T4: begin
                Zin    = 1'b1;
                Rout   = 1'b1;
                alu_op = ir[31 -: OP_W];
                if (cls.unary) Grb = 1'b1;
                else           Grc = 1'b1;
                state_nxt = T5;
            end
            T5: begin
                ZLowOut = 1'b1;
                if (cls.muldiv) begin
                    LOin      = 1'b1;
                    state_nxt = T6;
                end else begin
                    Gra       = 1'b1;
                    Rin       = 1'b1;
                    state_nxt = run ? T0 : IDLE;
                end
            end
            T6: begin
                ZHighOut  = 1'b1;
                HIin      = 1'b1;
                state_nxt = run ? T0 : IDLE;
            end
            HALT:    state_nxt = HALT;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = FAULT;
        endcase
    end

    assign halted  = (state == HALT);
    assign fault   = (state == FAULT);
    assign state_o = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class state by state
// against hand-derived strobe sets, plus per-cycle bus/register-select invariants.
module tb_control_sequencer;

    localparam logic [3:0] S_IDLE  = 4'h0;
    localparam logic [3:0] S_T0    = 4'h1;
    localparam logic [3:0] S_T1    = 4'h2;
    localparam logic [3:0] S_T2    = 4'h3;
    localparam logic [3:0] S_T3    = 4'h4;
    localparam logic [3:0] S_T4    = 4'h5;
    localparam logic [3:0] S_T5    = 4'h6;
    localparam logic [3:0] S_T6    = 4'h7;
    localparam logic [3:0] S_HALT  = 4'h8;
    localparam logic [3:0] S_FAULT = 4'h9;

    // strobe vector order: PCout..Rout, bit 17 down to bit 0
    localparam logic [17:0] B_PCOUT  = 18'h1 << 17;
    localparam logic [17:0] B_MARIN  = 18'h1 << 16;
    localparam logic [17:0] B_INCPC  = 18'h1 << 15;
    localparam logic [17:0] B_READ   = 18'h1 << 14;
    localparam logic [17:0] B_MDRIN  = 18'h1 << 13;
    localparam logic [17:0] B_MDROUT = 18'h1 << 12;
    localparam logic [17:0] B_IRIN   = 18'h1 << 11;
    localparam logic [17:0] B_YIN    = 18'h1 << 10;
    localparam logic [17:0] B_ZIN    = 18'h1 << 9;
    localparam logic [17:0] B_ZLO    = 18'h1 << 8;
    localparam logic [17:0] B_ZHI    = 18'h1 << 7;
    localparam logic [17:0] B_HIIN   = 18'h1 << 6;
    localparam logic [17:0] B_LOIN   = 18'h1 << 5;
    localparam logic [17:0] B_GRA    = 18'h1 << 4;
    localparam logic [17:0] B_GRB    = 18'h1 << 3;
    localparam logic [17:0] B_GRC    = 18'h1 << 2;
    localparam logic [17:0] B_RIN    = 18'h1 << 1;
    localparam logic [17:0] B_ROUT   = 18'h1 << 0;

    localparam logic [17:0] F_T0     = B_PCOUT | B_MARIN | B_INCPC;
    localparam logic [17:0] F_T1     = B_READ | B_MDRIN;
    localparam logic [17:0] F_T2     = B_MDROUT | B_IRIN;
    localparam logic [17:0] F_T3_BIN = B_GRB | B_ROUT | B_YIN;
    localparam logic [17:0] F_T4_BIN = B_GRC | B_ROUT | B_ZIN;
    localparam logic [17:0] F_T4_UN  = B_GRB | B_ROUT | B_ZIN;
    localparam logic [17:0] F_T5_WB  = B_ZLO | B_GRA | B_RIN;
    localparam logic [17:0] F_T5_MD  = B_ZLO | B_LOIN;
    localparam logic [17:0] F_T6_MD  = B_ZHI | B_HIIN;

    logic        clk = 1'b0;
    logic        clr, run, mem_rdy;
    logic [31:0] ir;
    logic PCout, MARin, incPC, Read, MDRin, MDRout, IRin, Yin, Zin;
    logic ZLowOut, ZHighOut, HIin, LOin, Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  alu_op;
    logic        halted, fault;
    logic [3:0]  state_o;
    logic [17:0] strobes;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    control_sequencer #(.OP_W(5), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_rdy(mem_rdy),
        .PCout(PCout), .MARin(MARin), .incPC(incPC), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .halted(halted), .fault(fault), .state_o(state_o)
    );

    assign strobes = {PCout, MARin, incPC, Read, MDRin, MDRout, IRin, Yin, Zin,
                      ZLowOut, ZHighOut, HIin, LOin, Gra, Grb, Grc, Rin, Rout};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic expect_st(input string tag, input logic [3:0] st,
                             input logic [17:0] strb, input logic [4:0] aop);
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".strobes"}, 32'(strobes), 32'(strb));
        check({tag, ".alu_op"}, 32'(alu_op), 32'(aop));
        check({tag, ".flags"}, 32'({halted, fault}), 32'({st == S_HALT, st == S_FAULT}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in T0 with mem_rdy high; leaves the sequencer in T3.
    task automatic fetch(input string tag);
        expect_st({tag, ".t0"}, S_T0, F_T0, 5'd0);
        tick();
        expect_st({tag, ".t1"}, S_T1, F_T1, 5'd0);
        tick();
        expect_st({tag, ".t2"}, S_T2, F_T2, 5'd0);
        tick();
    endtask

    // Async clear mid-cycle, released one edge later; leaves the sequencer in IDLE.
    task automatic do_reset(input string tag);
        clr = 1'b0;
        #1;
        expect_st({tag, ".async"}, S_IDLE, 18'h0, 5'd0);
        @(posedge clk);
        #1;
        clr = 1'b1;
    endtask

    always @(negedge clk) begin
        if (clr) begin
            check("one_bus_driver",
                  32'($countones({PCout, MDRout, Rout, ZLowOut, ZHighOut}) <= 1), 32'd1);
            if (Rin || Rout)
                check("one_reg_select", 32'($countones({Gra, Grb, Grc})), 32'd1);
        end
    end

    initial begin
        clr = 1'b0; run = 1'b0; mem_rdy = 1'b0; ir = 32'h0;
        #2;
        expect_st("reset_async", S_IDLE, 18'h0, 5'd0);
        tick(); tick();
        expect_st("reset_held", S_IDLE, 18'h0, 5'd0);
        clr = 1'b1;
        tick();
        expect_st("idle_no_run", S_IDLE, 18'h0, 5'd0);

        // and R1,R2,R3
        run = 1'b1; mem_rdy = 1'b1; ir = 32'h28918000;
        tick();
        fetch("and");
        expect_st("and.t3", S_T3, F_T3_BIN, 5'd0);
        tick();
        expect_st("and.t4", S_T4, F_T4_BIN, 5'b00101);
        tick();
        expect_st("and.t5", S_T5, F_T5_WB, 5'd0);
        tick();

        // mul: 7 cycles, LO then HI writeback, never Rin
        ir = 32'h70000000;
        fetch("mul");
        expect_st("mul.t3", S_T3, F_T3_BIN, 5'd0);
        tick();
        expect_st("mul.t4", S_T4, F_T4_BIN, 5'b01110);
        tick();
        expect_st("mul.t5", S_T5, F_T5_MD, 5'd0);
        tick();
        expect_st("mul.t6", S_T6, F_T6_MD, 5'd0);
        tick();

        // sub with three memory wait cycles
        ir = 32'h20000000; mem_rdy = 1'b0;
        expect_st("wait.t0", S_T0, F_T0, 5'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            expect_st("wait.t1_stall", S_T1, F_T1, 5'd0);
            tick();
        end
        mem_rdy = 1'b1;
        expect_st("wait.t1_rdy", S_T1, F_T1, 5'd0);
        tick();
        expect_st("wait.t2", S_T2, F_T2, 5'd0);
        tick();
        expect_st("sub.t3", S_T3, F_T3_BIN, 5'd0);
        tick();
        expect_st("sub.t4", S_T4, F_T4_BIN, 5'b00100);
        tick();
        expect_st("sub.t5", S_T5, F_T5_WB, 5'd0);
        tick();

        // memory never ready: 15 T1 cycles then FAULT, which absorbs
        mem_rdy = 1'b0;
        expect_st("tmo.t0", S_T0, F_T0, 5'd0);
        tick();
        for (int i = 0; i < 15; i++) begin
            expect_st("tmo.t1", S_T1, F_T1, 5'd0);
            tick();
        end
        expect_st("tmo.fault", S_FAULT, 18'h0, 5'd0);
        tick(); tick();
        expect_st("tmo.fault_held", S_FAULT, 18'h0, 5'd0);
        do_reset("tmo_clr");

        // ready on the 15th wait cycle beats the timeout; nop returns to T0
        ir = 32'hD0000000;
        tick();
        expect_st("edge.t0", S_T0, F_T0, 5'd0);
        tick();
        for (int i = 0; i < 14; i++) begin
            expect_st("edge.t1", S_T1, F_T1, 5'd0);
            tick();
        end
        mem_rdy = 1'b1;
        expect_st("edge.t1_last", S_T1, F_T1, 5'd0);
        tick();
        expect_st("edge.t2", S_T2, F_T2, 5'd0);
        tick();
        expect_st("nop.t3", S_T3, 18'h0, 5'd0);
        tick();

        // halt is absorbing even with run high
        ir = 32'hD8000000;
        fetch("halt");
        expect_st("halt.t3", S_T3, 18'h0, 5'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            expect_st("halt.held", S_HALT, 18'h0, 5'd0);
            tick();
        end
        do_reset("halt_clr");

        // illegal opcode 11111
        tick();
        ir = 32'hF8000000;
        fetch("ill");
        expect_st("ill.t3", S_T3, 18'h0, 5'd0);
        tick();
        expect_st("ill.fault", S_FAULT, 18'h0, 5'd0);
        do_reset("ill_clr");

        // neg: unary source via Grb in T4
        tick();
        ir = 32'h80000000;
        fetch("neg");
        expect_st("neg.t3", S_T3, 18'h0, 5'd0);
        tick();
        expect_st("neg.t4", S_T4, F_T4_UN, 5'b10000);
        tick();
        expect_st("neg.t5", S_T5, F_T5_WB, 5'd0);
        tick();

        // clear during T4 of an add
        ir = 32'h18000000;
        fetch("add_clr");
        expect_st("add_clr.t3", S_T3, F_T3_BIN, 5'd0);
        tick();
        expect_st("add_clr.t4", S_T4, F_T4_BIN, 5'b00011);
        do_reset("clr_t4");
        expect_st("clr_t4.released", S_IDLE, 18'h0, 5'd0);
        tick();

        // run dropped in T4: instruction completes, then IDLE
        fetch("add_stop");
        expect_st("add_stop.t3", S_T3, F_T3_BIN, 5'd0);
        tick();
        expect_st("add_stop.t4", S_T4, F_T4_BIN, 5'b00011);
        run = 1'b0;
        tick();
        expect_st("add_stop.t5", S_T5, F_T5_WB, 5'd0);
        tick();
        expect_st("add_stop.idle", S_IDLE, 18'h0, 5'd0);
        tick();
        expect_st("add_stop.idle2", S_IDLE, 18'h0, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
